// File: rtl/execute_muldiv_ctrl.sv
// Multi-cycle RV64M multiply/divide sequencer running beside the E-stage ALU.
// Define MD_FAST_MUL_EN for single-cycle multiply; CALC then serves only divide.
module execute_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regE_i_md_valid,
  input  logic [2:0]  regE_i_md_op,
  input  logic        regE_i_alu_W_instr,
  input  logic [63:0] regE_i_valA,
  input  logic [63:0] regE_i_valB,
  input  logic        regE_i_flush,
  output logic        md_o_busy,
  output logic        md_o_valid,
  output logic [63:0] md_o_result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state_reg;
  logic [6:0]   cnt_reg;
  logic [2:0]   op_reg;
  logic         w_reg;
  logic         neg_reg;
  logic         valid_reg;
  logic [63:0]  result_reg;
  logic [127:0] acc_reg;
  logic [127:0] mcand_reg;
  logic [63:0]  mplier_reg;
  logic [63:0]  q_reg;
  logic [63:0]  r_reg;
  logic [63:0]  d_reg;

  function automatic logic [63:0] w_fix(input logic [63:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Start-cycle decode: operand prep, magnitudes and special cases.
  logic        start, is_div, a_signed, b_signed, a_neg, b_neg;
  logic        div_zero, div_ovf, neg_start;
  logic [2:0]  op_eff;
  logic [63:0] a_prep, b_prep, a_mag, b_mag, min_val, special_res;

  always_comb begin
    start    = (state_reg == IDLE) && regE_i_md_valid && !regE_i_flush;
    // Reserved W encodings 1-3 fold onto MULW.
    op_eff   = (regE_i_alu_W_instr && !regE_i_md_op[2]) ? 3'd0 : regE_i_md_op;
    is_div   = op_eff[2];
    a_signed = (op_eff != 3'd3) && (op_eff != 3'd5) && (op_eff != 3'd7);
    b_signed = a_signed && (op_eff != 3'd2);
    if (regE_i_alu_W_instr) begin
      a_prep  = {{32{a_signed & regE_i_valA[31]}}, regE_i_valA[31:0]};
      b_prep  = {{32{b_signed & regE_i_valB[31]}}, regE_i_valB[31:0]};
      min_val = 64'hFFFF_FFFF_8000_0000;
    end else begin
      a_prep  = regE_i_valA;
      b_prep  = regE_i_valB;
      min_val = 64'h8000_0000_0000_0000;
    end
    a_neg     = a_signed & a_prep[63];
    b_neg     = b_signed & b_prep[63];
    a_mag     = a_neg ? -a_prep : a_prep;
    b_mag     = b_neg ? -b_prep : b_prep;
    neg_start = (is_div && op_eff[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div && (b_prep == 64'd0);
    div_ovf   = is_div && !op_eff[0] && (a_prep == min_val) && (b_prep == '1);
    if (div_zero) special_res = op_eff[1] ? a_prep : '1;
    else          special_res = op_eff[1] ? 64'd0 : a_prep;
  end

`ifdef MD_FAST_MUL_EN
  logic [127:0] fast_a, fast_b, fast_prod;
  logic [63:0]  fast_res;

  // Low 128 bits of the product of sign/zero-extended operands are exact.
  always_comb begin
    fast_a    = {{64{a_signed & a_prep[63]}}, a_prep};
    fast_b    = {{64{b_signed & b_prep[63]}}, b_prep};
    fast_prod = fast_a * fast_b;
    fast_res  = w_fix((op_eff[1:0] == 2'd0) ? fast_prod[63:0] : fast_prod[127:64],
                      regE_i_alu_W_instr);
  end
`endif

  // One iteration of shift-add multiply and restoring divide, plus result fixup.
  logic [127:0] acc_step, prod_fix;
  logic [64:0]  div_sh, div_diff;
  logic         div_ge;
  logic [63:0]  q_step, r_step, q_fix, r_fix, calc_raw, calc_res;

  always_comb begin
    acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    div_sh   = {r_reg, q_reg[63]};
    div_diff = div_sh - {1'b0, d_reg};
    // Remainder stays below the divisor, so bit 64 of the difference is the borrow.
    div_ge   = !div_diff[64];
    q_step   = {q_reg[62:0], div_ge};
    r_step   = div_ge ? div_diff[63:0] : div_sh[63:0];
    prod_fix = neg_reg ? -acc_step : acc_step;
    q_fix    = neg_reg ? -q_step : q_step;
    r_fix    = neg_reg ? -r_step : r_step;
    if (op_reg[2])                calc_raw = op_reg[1] ? r_fix : q_fix;
    else if (op_reg[1:0] == 2'd0) calc_raw = prod_fix[63:0];
    else                          calc_raw = prod_fix[127:64];
    calc_res = w_fix(calc_raw, w_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 7'd0;
      op_reg     <= 3'd0;
      w_reg      <= 1'b0;
      neg_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= 64'd0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      d_reg      <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg     <= op_eff;
            w_reg      <= regE_i_alu_W_instr;
            neg_reg    <= neg_start;
            cnt_reg    <= regE_i_alu_W_instr ? 7'd32 : 7'd64;
            acc_reg    <= '0;
            mcand_reg  <= {64'd0, a_mag};
            mplier_reg <= b_mag;
            // W dividends are pre-aligned so the next dividend bit is always q_reg[63].
            q_reg      <= regE_i_alu_W_instr ? {a_mag[31:0], 32'd0} : a_mag;
            r_reg      <= '0;
            d_reg      <= b_mag;
            if (div_zero || div_ovf) begin
              result_reg <= w_fix(special_res, regE_i_alu_W_instr);
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end
`ifdef MD_FAST_MUL_EN
            else if (!is_div) begin
              result_reg <= fast_res;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end
`endif
            else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (regE_i_flush) begin
            state_reg <= IDLE;
            cnt_reg   <= 7'd0;
          end else begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            q_reg      <= q_step;
            r_reg      <= r_step;
            cnt_reg    <= cnt_reg - 7'd1;
            if (cnt_reg == 7'd1) begin
              result_reg <= calc_res;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign md_o_busy   = start || (state_reg == CALC);
  assign md_o_valid  = valid_reg;
  assign md_o_result = result_reg;
endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Directed self-checking bench for execute_muldiv_ctrl (latency, results, flush, reset).
`timescale 1ns/1ps
module tb_execute_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        w = 1'b0;
  logic [63:0] va = 64'd0;
  logic [63:0] vb = 64'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        valid;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif

  always #5 clk = ~clk;

  execute_muldiv_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .regE_i_md_valid   (md_valid),
    .regE_i_md_op      (op),
    .regE_i_alu_W_instr(w),
    .regE_i_valA       (va),
    .regE_i_valB       (vb),
    .regE_i_flush      (flush),
    .md_o_busy         (busy),
    .md_o_valid        (valid),
    .md_o_result       (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the next IDLE cycle, hold it like a stalled pipeline, time the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic wi,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    int   gaps;
    logic got;
    tick();
    check({tag, "_idle_valid"}, {63'd0, valid}, 64'd0);
    op = o; w = wi; va = a; vb = b; md_valid = 1'b1;
    #1;
    check({tag, "_start_busy"}, {63'd0, busy}, 64'd1);
    lat = 0; gaps = 0; got = 1'b0;
    while (!got && lat < 200) begin
      tick();
      lat++;
      if (valid) got = 1'b1;
      else begin
        if (!busy) gaps++;
        va = {$urandom, $urandom};
        vb = {$urandom, $urandom};
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_busy_gaps"}, 64'(gaps), 64'd0);
    $display("op=%0d w=%0d a=%h b=%h result=%h latency=%0d", o, wi, a, b, result, lat);
    md_valid = 1'b0;
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_result", result, 64'd0);
    rst_n = 1'b1;

    run_op("mul",      3'd0, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run_op("mulhu",    3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    run_op("mulhsu",   3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run_op("mulh",     3'd1, 1'b0, '1, '1, 64'd0, MUL_LAT);
    run_op("mulw_rsv", 3'd3, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
    run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", 3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
    run_op("div_z",    3'd4, 1'b0, 64'd100, 64'd0, '1, 1);
    run_op("remu_z",   3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    run_op("div_ovf",  3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_neg",  3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div_neg",  3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("divu_big", 3'd5, 1'b0, '1, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65);
    run_op("remuw_z",  3'd7, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'h0000_0001_0000_0000,
           64'hFFFF_FFFF_8000_0005, 1);
    run_op("divuw_a",  3'd5, 1'b1, 64'd20, 64'd3, 64'd6, 33);
    run_op("divuw_b",  3'd5, 1'b1, 64'd20, 64'd6, 64'd3, 33);

    // Flush at CALC cycle 10 of a divu.
    tick();
    op = 3'd5; w = 1'b0; va = 64'd1000; vb = 64'd7; md_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("flush_calc_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; md_valid = 1'b0;
    check("flush_valid", {63'd0, valid}, 64'd0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_result", result, 64'd3);
    vcount = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (valid) vcount++;
    end
    check("flush_no_valid", 64'(vcount), 64'd0);
    $display("flush mid-calc: result=%h stray_valids=%0d", result, vcount);

    // Flush coinciding with a request suppresses the start.
    op = 3'd4; va = 64'd5; vb = 64'd1; md_valid = 1'b1; flush = 1'b1;
    #1;
    check("flushreq_busy", {63'd0, busy}, 64'd0);
    tick();
    md_valid = 1'b0; flush = 1'b0;
    check("flushreq_busy_next", {63'd0, busy}, 64'd0);
    check("flushreq_valid", {63'd0, valid}, 64'd0);
    tick();
    check("flushreq_valid2", {63'd0, valid}, 64'd0);
    check("flushreq_result", result, 64'd3);
    $display("flush with request: busy=%0d valid=%0d result=%h", busy, valid, result);

    // Reset mid-CALC.
    op = 3'd4; w = 1'b0; va = 64'd1000; vb = 64'd7; md_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0; md_valid = 1'b0;
    tick();
    check("rstcalc_valid", {63'd0, valid}, 64'd0);
    check("rstcalc_busy", {63'd0, busy}, 64'd0);
    check("rstcalc_result", result, 64'd0);
    $display("reset mid-calc: busy=%0d valid=%0d result=%h", busy, valid, result);
    rst_n = 1'b1;

    run_op("divu_post", 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 65);
    run_op("remu_post", 3'd7, 1'b0, 64'd1000, 64'd7, 64'd6, 65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
